// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller, stall/flush
// pins, the timeout flag and the performance counters back out.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_rs;
    logic [4:0]       ID_rt;
    logic             ID_use_rs;
    logic             ID_use_rt;
    logic             EX_memtoreg;
    logic [4:0]       EX_wreg;
    logic             EX_redirect;
    logic             MEM_req;
    logic             MEM_ack;
    logic             cnt_clr;

    logic             pc_stall;
    logic             IF_ID_stall;
    logic             ID_EX_stall;
    logic             EX_MEM_stall;
    logic             MEM_WB_stall;
    logic             IF_ID_flush;
    logic             ID_EX_flush;
    logic             EX_MEM_flush;
    logic             MEM_WB_flush;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    // The pipeline side drives status and consumes the control pins.
    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_memtoreg, EX_wreg,
               EX_redirect, MEM_req, MEM_ack, cnt_clr,
        input  pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               mem_err, stall_cycles, flush_events
    );

    // The controller side reads status and drives the control pins.
    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, EX_memtoreg, EX_wreg,
               EX_redirect, MEM_req, MEM_ack, cnt_clr,
        output pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush,
               mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use bubble,
// redirect squash, memory wait freeze, memory timeout and saturating counters.
module pipe_hazard_ctrl #(
    parameter int WAIT_MAX = 255,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_WAIT, S_HALT} state_t;

    localparam logic [15:0]      L_WAIT_MAX = 16'(WAIT_MAX);
    localparam logic [CNT_W-1:0] L_ONE      = CNT_W'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [15:0]      r_waitCnt;
    logic [15:0]      w_nextWaitCnt;
    logic             r_memErr;
    logic             w_nextMemErr;
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;

    logic w_memwait;
    logic w_ldhaz;
    logic w_pcStall;
    logic w_ifIdStall;
    logic w_idExStall;
    logic w_exMemStall;
    logic w_memWbStall;
    logic w_ifIdFlush;
    logic w_idExFlush;
    logic w_exMemFlush;
    logic w_memWbFlush;
    logic w_anyFlush;

    assign w_memwait = bus.MEM_req & ~bus.MEM_ack;
    assign w_ldhaz   = bus.EX_memtoreg & (bus.EX_wreg != 5'd0) &
                       ((bus.ID_use_rs & (bus.ID_rs == bus.EX_wreg)) |
                        (bus.ID_use_rt & (bus.ID_rt == bus.EX_wreg)));

    // Priority: halt > memory wait > redirect > load-use; all pins low in reset.
    always_comb begin
        w_pcStall    = 1'b0;
        w_ifIdStall  = 1'b0;
        w_idExStall  = 1'b0;
        w_exMemStall = 1'b0;
        w_memWbStall = 1'b0;
        w_ifIdFlush  = 1'b0;
        w_idExFlush  = 1'b0;
        w_exMemFlush = 1'b0;
        w_memWbFlush = 1'b0;
        if (rst_n) begin
            if (r_state == S_HALT) begin
                w_pcStall    = 1'b1;
                w_ifIdStall  = 1'b1;
                w_idExStall  = 1'b1;
                w_exMemStall = 1'b1;
                w_memWbStall = 1'b1;
            end else if (w_memwait) begin
                w_pcStall    = 1'b1;
                w_ifIdStall  = 1'b1;
                w_idExStall  = 1'b1;
                w_exMemStall = 1'b1;
                w_memWbFlush = 1'b1;
            end else if (bus.EX_redirect) begin
                w_ifIdFlush  = 1'b1;
                w_idExFlush  = 1'b1;
            end else if (w_ldhaz) begin
                w_pcStall    = 1'b1;
                w_ifIdStall  = 1'b1;
                w_idExFlush  = 1'b1;
            end
        end
    end

    assign w_anyFlush = w_ifIdFlush | w_idExFlush | w_exMemFlush | w_memWbFlush;

    // Next state: count consecutive wait cycles and halt once WAIT_MAX is exceeded.
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = r_waitCnt;
        w_nextMemErr  = r_memErr;
        case (r_state)
            S_RUN: begin
                if (w_memwait) begin
                    w_nextState   = S_WAIT;
                    w_nextWaitCnt = 16'd1;
                end
            end
            S_WAIT: begin
                if (!w_memwait) begin
                    w_nextState   = S_RUN;
                    w_nextWaitCnt = 16'd0;
                end else if (r_waitCnt == L_WAIT_MAX) begin
                    w_nextState  = S_HALT;
                    w_nextMemErr = 1'b1;
                end else begin
                    w_nextWaitCnt = r_waitCnt + 16'd1;
                end
            end
            S_HALT: begin
                w_nextState = S_HALT;
            end
            default: begin
                w_nextState   = S_RUN;
                w_nextWaitCnt = 16'd0;
            end
        endcase
    end

    // State, wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_waitCnt <= 16'd0;
            r_memErr  <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            r_memErr  <= w_nextMemErr;
        end
    end

    // Saturating performance counters; a clear wins over a same-cycle event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else if (bus.cnt_clr) begin
            r_stallCnt <= '0;
            r_flushCnt <= '0;
        end else begin
            if (w_pcStall && (r_stallCnt != '1)) begin
                r_stallCnt <= r_stallCnt + L_ONE;
            end
            if (w_anyFlush && (r_flushCnt != '1)) begin
                r_flushCnt <= r_flushCnt + L_ONE;
            end
        end
    end

    assign bus.pc_stall     = w_pcStall;
    assign bus.IF_ID_stall  = w_ifIdStall;
    assign bus.ID_EX_stall  = w_idExStall;
    assign bus.EX_MEM_stall = w_exMemStall;
    assign bus.MEM_WB_stall = w_memWbStall;
    assign bus.IF_ID_flush  = w_ifIdFlush;
    assign bus.ID_EX_flush  = w_idExFlush;
    assign bus.EX_MEM_flush = w_exMemFlush;
    assign bus.MEM_WB_flush = w_memWbFlush;
    assign bus.mem_err      = r_memErr;
    assign bus.stall_cycles = r_stallCnt;
    assign bus.flush_events = r_flushCnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios, random traffic and a
// timeout/saturation run, all checked against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int WAIT_MAX = 4;
    localparam int CNT_W    = 8;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // Reference model state: consecutive wait cycles, halted flag, counters.
    int   mStreak;
    bit   mHalted;
    int   mStall;
    int   mFlush;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

    pipe_hazard_ctrl #(
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (hif.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pins {pc, IF_ID/ID_EX/EX_MEM/MEM_WB stall, IF_ID/ID_EX/EX_MEM/MEM_WB flush}.
    function automatic logic [8:0] expOut();
        logic memwait;
        logic ldhaz;
        memwait = hif.MEM_req && !hif.MEM_ack;
        ldhaz   = hif.EX_memtoreg && (hif.EX_wreg != 0) &&
                  ((hif.ID_use_rs && hif.ID_rs == hif.EX_wreg) ||
                   (hif.ID_use_rt && hif.ID_rt == hif.EX_wreg));
        if (!rst_n)           return 9'b0_0000_0000;
        if (mHalted)          return 9'b1_1111_0000;
        if (memwait)          return 9'b1_1110_0001;
        if (hif.EX_redirect)  return 9'b0_0000_1100;
        if (ldhaz)            return 9'b1_1000_0100;
        return 9'b0_0000_0000;
    endfunction

    function automatic logic [8:0] obsOut();
        return {hif.pc_stall, hif.IF_ID_stall, hif.ID_EX_stall, hif.EX_MEM_stall,
                hif.MEM_WB_stall, hif.IF_ID_flush, hif.ID_EX_flush,
                hif.EX_MEM_flush, hif.MEM_WB_flush};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_err"},   32'(hif.mem_err),      32'(mHalted));
        checkOutput({tag, "_stall"}, 32'(hif.stall_cycles), 32'(mStall));
        checkOutput({tag, "_flush"}, 32'(hif.flush_events), 32'(mFlush));
    endtask

    task automatic driveInputs(input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic ld,
                               input logic [4:0] wreg, input logic redir,
                               input logic req, input logic ack, input logic clr);
        hif.ID_rs       = rs;
        hif.ID_rt       = rt;
        hif.ID_use_rs   = urs;
        hif.ID_use_rt   = urt;
        hif.EX_memtoreg = ld;
        hif.EX_wreg     = wreg;
        hif.EX_redirect = redir;
        hif.MEM_req     = req;
        hif.MEM_ack     = ack;
        hif.cnt_clr     = clr;
    endtask

    // One pipeline cycle: drive, check the pins mid-cycle, advance the model.
    task automatic applyStimulus(input string tag, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic urs,
                                 input logic urt, input logic ld,
                                 input logic [4:0] wreg, input logic redir,
                                 input logic req, input logic ack, input logic clr);
        logic [8:0] exp;
        @(negedge clk);
        driveInputs(rs, rt, urs, urt, ld, wreg, redir, req, ack, clr);
        #1;
        exp = expOut();
        checkOutput({tag, "_pins"}, 32'(obsOut()), 32'(exp));
        @(posedge clk);
        if (!mHalted) begin
            if (req && !ack) mStreak++;
            else             mStreak = 0;
            if (mStreak == WAIT_MAX + 1) mHalted = 1'b1;
        end
        if (clr) begin
            mStall = 0;
            mFlush = 0;
        end else begin
            if (exp[8] && mStall < CNT_MAX)      mStall++;
            if ((|exp[3:0]) && mFlush < CNT_MAX) mFlush++;
        end
        #1;
        checkStatus(tag);
    endtask

    // Asynchronous reset pulse with every hazard active, then release when idle.
    task automatic doReset(input string tag);
        @(negedge clk);
        driveInputs(5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        mStreak = 0;
        mHalted = 1'b0;
        mStall  = 0;
        mFlush  = 0;
        checkOutput({tag, "_rstpins"}, 32'(obsOut()), 32'd0);
        checkStatus({tag, "_rst"});
        driveInputs('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        mStreak = 0;
        mHalted = 1'b0;
        mStall  = 0;
        mFlush  = 0;
        rst_n   = 1'b1;
        driveInputs('0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        doReset("init");
        applyStimulus("idle", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);

        // Load-use on rs: one bubble, one stall cycle, one flush event.
        applyStimulus("ldrs", 5'd5, 5'd9, 1, 0, 1, 5'd5, 0, 0, 0, 0);
        checkOutput("ldrs_stallcnt", 32'(hif.stall_cycles), 32'd1);
        checkOutput("ldrs_flushcnt", 32'(hif.flush_events), 32'd1);
        applyStimulus("ldrs_after", 5'd5, 5'd9, 1, 0, 0, 5'd5, 0, 0, 0, 0);
        // Load-use on rt, then a load to $0 that must not hazard.
        applyStimulus("ldrt", 5'd1, 5'd7, 0, 1, 1, 5'd7, 0, 0, 0, 0);
        applyStimulus("ldzero", 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, 0, 0);
        applyStimulus("ldnouse", 5'd5, 5'd5, 0, 0, 1, 5'd5, 0, 0, 0, 0);

        // Redirect together with a load-use: squash only.
        applyStimulus("redir_ld", 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0);

        // Three wait cycles with redirect held, then the ack cycle.
        for (int i = 0; i < 3; i++)
            applyStimulus("memwait", 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 0, 0);
        applyStimulus("memack", 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, 1, 0);
        applyStimulus("memdone", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        applyStimulus("ackzero", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0);

        // Clear during a stall cycle drops that event.
        applyStimulus("clrstall", 5'd3, 5'd0, 1, 0, 1, 5'd3, 0, 0, 0, 1);
        checkOutput("clr_zero", 32'(hif.stall_cycles), 32'd0);

        // Random traffic with a fresh reset per round.
        for (int r = 0; r < 3; r++) begin
            doReset("rnd_rst");
            for (int i = 0; i < 150; i++) begin
                applyStimulus("rnd",
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 30) == 0));
            end
        end

        // Timeout: WAIT_MAX+1 unacked cycles, then the pipe stays frozen.
        doReset("to_rst");
        for (int i = 0; i < WAIT_MAX + 1; i++)
            applyStimulus("towait", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);
        checkOutput("to_memerr", 32'(hif.mem_err), 32'd1);
        for (int i = 0; i < CNT_MAX + 5; i++)
            applyStimulus("halt", 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 0, 0, 0);
        checkOutput("sat_stall", 32'(hif.stall_cycles), 32'(CNT_MAX));
        applyStimulus("halt_clr", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1);
        checkOutput("halt_clr_zero", 32'(hif.stall_cycles), 32'd0);

        // Reset out of HALT returns to normal operation.
        doReset("halt_rst");
        applyStimulus("post_halt", 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0);
        applyStimulus("post_ld", 5'd4, 5'd0, 1, 0, 1, 5'd4, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
